// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial controller sharing one 8-bit RAM port between instruction fetch and
// load/store traffic. Little-endian assembly/disassembly, one-cycle done pulse per requester.
module mem_ctrl #(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  input  logic                  if_flush_i,
  output logic                  if_done_o,
  output logic [31:0]           if_data_o,
  input  logic                  mem_req_i,
  input  logic                  mem_we_i,
  input  logic [1:0]            mem_size_i,
  input  logic [ADDR_WIDTH-1:0] mem_addr_i,
  input  logic [31:0]           mem_wdata_i,
  output logic                  mem_done_o,
  output logic [31:0]           mem_rdata_o,
  input  logic [7:0]            ram_din_i,
  output logic [7:0]            ram_dout_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_wr_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {StIdle, StIfRd, StMemRd, StMemWr, StDone} state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            nbytes_q, nbytes_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  is_if_q, is_if_d;
  logic [31:0]           asm_q, asm_d;
  logic [31:0]           if_data_q, if_data_d;
  logic [31:0]           mem_rdata_q, mem_rdata_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [1:0]            rd_idx_q, rd_idx_d;
  logic                  reading, issuing;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    nbytes_d    = nbytes_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    is_if_d     = is_if_q;
    if_data_d   = if_data_q;
    mem_rdata_d = mem_rdata_q;
    asm_d       = asm_q;
    ram_addr_o  = '0;
    ram_dout_o  = '0;
    ram_wr_o    = 1'b0;
    if_done_o   = 1'b0;
    mem_done_o  = 1'b0;

    reading  = (state_q == StIfRd) || (state_q == StMemRd);
    issuing  = reading && (cnt_q < nbytes_q);
    // Track the byte index on the bus every cycle, stalled or not, so the byte returned for
    // the address held during a stall always lands in the right lane.
    rd_vld_d = issuing;
    rd_idx_d = cnt_q[1:0];
    if (reading && rd_vld_q) asm_d[{rd_idx_q, 3'b000} +: 8] = ram_din_i;
    if (issuing) ram_addr_o = addr_q + ADDR_WIDTH'(cnt_q);

    unique case (state_q)
      StIdle: begin
        if (rdy) begin
          if (mem_req_i) begin
            state_d  = mem_we_i ? StMemWr : StMemRd;
            is_if_d  = 1'b0;
            addr_d   = mem_addr_i;
            wdata_d  = mem_wdata_i;
            nbytes_d = (mem_size_i == 2'b00) ? 3'd1 : (mem_size_i == 2'b01) ? 3'd2 : 3'd4;
            cnt_d    = '0;
            asm_d    = '0;
          end else if (if_req_i && !if_flush_i) begin
            state_d  = StIfRd;
            is_if_d  = 1'b1;
            addr_d   = if_addr_i;
            nbytes_d = 3'd4;
            cnt_d    = '0;
            asm_d    = '0;
          end
        end
      end
      StIfRd, StMemRd: begin
        if (rdy) begin
          if ((state_q == StIfRd) && if_flush_i) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == nbytes_q) begin
            state_d = StDone;
            if (is_if_q) if_data_d = asm_d;
            else         mem_rdata_d = asm_d;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      StMemWr: begin
        ram_addr_o = addr_q + ADDR_WIDTH'(cnt_q);
        ram_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        ram_wr_o   = rdy;
        if (rdy) begin
          if (cnt_q == nbytes_q - 3'd1) state_d = StDone;
          else                          cnt_d   = cnt_q + 3'd1;
        end
      end
      StDone: begin
        if_done_o  = rdy && is_if_q;
        mem_done_o = rdy && !is_if_q;
        if (rdy) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      nbytes_q    <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      is_if_q     <= 1'b0;
      asm_q       <= '0;
      if_data_q   <= '0;
      mem_rdata_q <= '0;
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      nbytes_q    <= nbytes_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      is_if_q     <= is_if_d;
      asm_q       <= asm_d;
      if_data_q   <= if_data_d;
      mem_rdata_q <= mem_rdata_d;
      rd_vld_q    <= rd_vld_d;
      rd_idx_q    <= rd_idx_d;
    end
  end

  assign if_data_o   = if_data_q;
  assign mem_rdata_o = mem_rdata_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: byte-wide RAM with one-cycle read latency, scenario tasks and a
// randomized run checked against a byte-array memory model.
module tb_mem_ctrl;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        if_req_i, if_flush_i, if_done_o;
  logic [31:0] if_addr_i, if_data_o;
  logic        mem_req_i, mem_we_i, mem_done_o;
  logic [1:0]  mem_size_i;
  logic [31:0] mem_addr_i, mem_wdata_i, mem_rdata_o;
  logic [7:0]  ram_din_i, ram_dout_o;
  logic [31:0] ram_addr_o;
  logic        ram_wr_o, busy_o;

  int n_cmp = 0;
  int n_fail = 0;
  logic [31:0] last_if;

  logic [7:0] ram     [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  mem_ctrl #(.ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_done_o(if_done_o), .if_data_o(if_data_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_size_i(mem_size_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
    .ram_din_i(ram_din_i), .ram_dout_o(ram_dout_o), .ram_addr_o(ram_addr_o),
    .ram_wr_o(ram_wr_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
  endfunction

  // Little-endian read of n bytes from the model, upper bytes zero.
  function automatic logic [31:0] model_read(input logic [31:0] a, input int n);
    logic [31:0] r = '0;
    for (int i = 0; i < n; i++) r[8*i +: 8] = ref_rd(a + 32'(i));
    return r;
  endfunction

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  always @(posedge clk) ram_din_i <= ram_rd(ram_addr_o);
  always @(posedge clk) if (ram_wr_o) ram[ram_addr_o] = ram_dout_o;

  task automatic poke(input logic [31:0] a, input logic [7:0] v);
    ram[a] = v;
    ref_mem[a] = v;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 50 && busy_o; k++) @(negedge clk);
  endtask

  task automatic mem_txn(input logic we, input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd, output int lat, output logic [31:0] rd);
    wait_idle();
    mem_req_i = 1'b1; mem_we_i = we; mem_size_i = sz; mem_addr_i = a; mem_wdata_i = wd;
    @(posedge clk);
    lat = -1; rd = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      mem_addr_i = $urandom; mem_wdata_i = $urandom;
      if (mem_done_o) begin lat = k; rd = mem_rdata_o; break; end
    end
    mem_req_i = 1'b0;
  endtask

  task automatic if_txn(input logic [31:0] a, output int lat, output logic [31:0] rd);
    wait_idle();
    if_req_i = 1'b1; if_addr_i = a;
    @(posedge clk);
    lat = -1; rd = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if_addr_i = $urandom;
      if (if_done_o) begin lat = k; rd = if_data_o; break; end
    end
    if_req_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; rdy = 1'b1;
    if_req_i = 1'b0; if_flush_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_size_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({if_done_o, mem_done_o, ram_wr_o, busy_o} !== 4'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000",
                         {if_done_o, mem_done_o, ram_wr_o, busy_o});
    end
    n_cmp++;
    if ({if_data_o, mem_rdata_o} !== 64'h0) begin
      n_fail++; $display("FAIL reset_data: got %h %h expected 0", if_data_o, mem_rdata_o);
    end
    n_cmp++;
    if ({ram_addr_o, ram_dout_o} !== 40'h0) begin
      n_fail++; $display("FAIL reset_bus: got %h %h expected 0", ram_addr_o, ram_dout_o);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int done_k = -1;
    logic wr_seen = 1'b0;
    logic [31:0] d = 'x;
    poke(32'h100, 8'h13); poke(32'h101, 8'h05); poke(32'h102, 8'hA0); poke(32'h103, 8'h00);
    wait_idle();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (ram_wr_o) wr_seen = 1'b1;
      if (k < 4) begin
        n_cmp++;
        if (ram_addr_o !== 32'h100 + 32'(k)) begin
          n_fail++; $display("FAIL fetch_addr c%0d: got %h expected %h", k, ram_addr_o,
                             32'h100 + 32'(k));
        end
      end
      if (if_done_o) begin done_k = k; d = if_data_o; break; end
    end
    if_req_i = 1'b0;
    n_cmp++;
    if (done_k !== 5) begin n_fail++; $display("FAIL fetch_lat: got %0d expected 5", done_k); end
    n_cmp++;
    if (d !== 32'h00A00513) begin
      n_fail++; $display("FAIL fetch_data: got %h expected 00a00513", d);
    end
    n_cmp++;
    if (wr_seen !== 1'b0) begin n_fail++; $display("FAIL fetch_nowr: got 1 expected 0"); end
    last_if = 32'h00A00513;
  endtask

  task automatic test_half_store();
    int done_k = -1;
    poke(32'h20000, 8'h5A);
    wait_idle();
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b01;
    mem_addr_i = 32'h1FFFE; mem_wdata_i = 32'hDEADBEEF;
    @(posedge clk);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k < 2) begin
        n_cmp++;
        if ({ram_wr_o, ram_addr_o, ram_dout_o} !==
            {1'b1, 32'h1FFFE + 32'(k), (k == 0) ? 8'hEF : 8'hBE}) begin
          n_fail++; $display("FAIL hstore_bus c%0d: got wr=%b a=%h d=%h", k, ram_wr_o,
                             ram_addr_o, ram_dout_o);
        end
      end
      if (mem_done_o) begin done_k = k; break; end
    end
    mem_req_i = 1'b0;
    ref_mem[32'h1FFFE] = 8'hEF; ref_mem[32'h1FFFF] = 8'hBE;
    n_cmp++;
    if (done_k !== 2) begin n_fail++; $display("FAIL hstore_lat: got %0d expected 2", done_k); end
    n_cmp++;
    if ({ram_rd(32'h1FFFE), ram_rd(32'h1FFFF), ram_rd(32'h20000)} !== 24'hEFBE5A) begin
      n_fail++; $display("FAIL hstore_ram: got %h%h%h expected efbe5a", ram_rd(32'h1FFFE),
                         ram_rd(32'h1FFFF), ram_rd(32'h20000));
    end
  endtask

  task automatic test_arbitration();
    int mem_k = -1, if_k = -1;
    logic [31:0] mrd = 'x, ird = 'x;
    poke(32'h30000, 8'h80);
    for (int i = 0; i < 4; i++) poke(32'(i), 8'($urandom));
    wait_idle();
    if_req_i = 1'b1; if_addr_i = 32'h0;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b00; mem_addr_i = 32'h30000;
    @(posedge clk);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (mem_done_o) begin mem_k = k; mrd = mem_rdata_o; mem_req_i = 1'b0; end
      if (if_done_o) begin if_k = k; ird = if_data_o; break; end
    end
    if_req_i = 1'b0; mem_req_i = 1'b0;
    n_cmp++;
    if (mem_k !== 2) begin n_fail++; $display("FAIL arb_mem_lat: got %0d expected 2", mem_k); end
    n_cmp++;
    if (mrd !== 32'h80) begin n_fail++; $display("FAIL arb_mem_data: got %h expected 80", mrd); end
    n_cmp++;
    if (if_k !== 9) begin n_fail++; $display("FAIL arb_if_lat: got %0d expected 9", if_k); end
    n_cmp++;
    if (ird !== model_read(32'h0, 4)) begin
      n_fail++; $display("FAIL arb_if_data: got %h expected %h", ird, model_read(32'h0, 4));
    end
    last_if = model_read(32'h0, 4);
  endtask

  task automatic test_flush();
    int done_k = -1;
    logic early = 1'b0;
    logic [31:0] d = 'x;
    for (int i = 0; i < 4; i++) poke(32'h200 + 32'(i), 8'($urandom));
    wait_idle();
    if_req_i = 1'b1; if_addr_i = 32'h100;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k == 2) begin if_flush_i = 1'b1; if_addr_i = 32'h200; end
      if (k == 3) begin
        n_cmp++;
        if ({busy_o, if_done_o} !== 2'b00) begin
          n_fail++; $display("FAIL flush_idle: got busy=%b done=%b expected 0 0", busy_o,
                             if_done_o);
        end
        n_cmp++;
        if (if_data_o !== last_if) begin
          n_fail++; $display("FAIL flush_keep: got %h expected %h", if_data_o, last_if);
        end
        if_flush_i = 1'b0;
      end
      if (if_done_o) begin
        if (k < 4) early = 1'b1;
        else begin done_k = k; d = if_data_o; break; end
      end
    end
    if_req_i = 1'b0; if_flush_i = 1'b0;
    n_cmp++;
    if (early !== 1'b0) begin n_fail++; $display("FAIL flush_nodone: got 1 expected 0"); end
    n_cmp++;
    if (done_k !== 9) begin n_fail++; $display("FAIL flush_relat: got %0d expected 9", done_k); end
    n_cmp++;
    if (d !== model_read(32'h200, 4)) begin
      n_fail++; $display("FAIL flush_redata: got %h expected %h", d, model_read(32'h200, 4));
    end
    last_if = model_read(32'h200, 4);
  endtask

  task automatic test_stall();
    int done_k = -1;
    logic [31:0] base = 32'h4000_0000 + 32'($urandom_range(0, 1000));
    logic [31:0] d = 'x;
    for (int i = 0; i < 4; i++) poke(base + 32'(i), 8'($urandom));
    wait_idle();
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_size_i = 2'b10; mem_addr_i = base;
    @(posedge clk);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k >= 2 && k <= 5) begin
        n_cmp++;
        if ({ram_addr_o, ram_wr_o, mem_done_o} !== {base + 32'd2, 2'b00}) begin
          n_fail++; $display("FAIL stall_hold c%0d: got a=%h wr=%b done=%b expected a=%h", k,
                             ram_addr_o, ram_wr_o, mem_done_o, base + 32'd2);
        end
      end
      if (k == 2) rdy = 1'b0;
      if (k == 5) rdy = 1'b1;
      if (mem_done_o) begin done_k = k; d = mem_rdata_o; break; end
    end
    mem_req_i = 1'b0; rdy = 1'b1;
    n_cmp++;
    if (done_k !== 8) begin n_fail++; $display("FAIL stall_lat: got %0d expected 8", done_k); end
    n_cmp++;
    if (d !== model_read(base, 4)) begin
      n_fail++; $display("FAIL stall_data: got %h expected %h", d, model_read(base, 4));
    end
  endtask

  task automatic test_reset_mid_store();
    logic [31:0] base = 32'h5000 + 32'($urandom_range(0, 255));
    logic [31:0] wd = $urandom;
    logic done_seen = 1'b0;
    for (int i = 0; i < 4; i++) poke(base + 32'(i), 8'h11);
    wait_idle();
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_size_i = 2'b10; mem_addr_i = base; mem_wdata_i = wd;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ram_addr_o, ram_dout_o, ram_wr_o, busy_o, mem_done_o, if_done_o} !== 44'h0 ||
        {if_data_o, mem_rdata_o} !== 64'h0) begin
      n_fail++; $display("FAIL rstmid_outs: got a=%h d=%h wr=%b busy=%b md=%b id=%b %h %h",
                         ram_addr_o, ram_dout_o, ram_wr_o, busy_o, mem_done_o, if_done_o,
                         if_data_o, mem_rdata_o);
    end
    rst = 1'b0; mem_req_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (mem_done_o) done_seen = 1'b1;
    end
    ref_mem[base] = wd[7:0]; ref_mem[base + 32'd1] = wd[15:8];
    n_cmp++;
    if (done_seen !== 1'b0) begin n_fail++; $display("FAIL rstmid_nodone: got 1 expected 0"); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (ram_rd(base + 32'(i)) !== ref_rd(base + 32'(i))) begin
        n_fail++; $display("FAIL rstmid_ram+%0d: got %h expected %h", i, ram_rd(base + 32'(i)),
                           ref_rd(base + 32'(i)));
      end
    end
    last_if = 32'h0;
  endtask

  task automatic test_random();
    logic [31:0] a, wd, rd, exp;
    logic [1:0]  sz;
    int          lat, n, kind;
    for (int i = 0; i < 256; i++) poke(32'h4000 + 32'(i), 8'($urandom));
    for (int i = 0; i < 8; i++) poke(32'hFFFF_FFF8 + 32'(i), 8'($urandom));
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      else                           a = 32'h4000 + 32'($urandom_range(0, 250));
      kind = $urandom_range(0, 2);
      sz   = 2'($urandom_range(0, 3));
      wd   = $urandom;
      n    = size_bytes(sz);
      if (kind == 0) begin
        exp = model_read(a, 4);
        if_txn(a, lat, rd);
        n_cmp++;
        if (lat !== 5 || rd !== exp) begin
          n_fail++; $display("FAIL rnd_fetch @%h: got lat=%0d d=%h expected lat=5 d=%h", a,
                             lat, rd, exp);
        end
      end else if (kind == 1) begin
        exp = model_read(a, n);
        mem_txn(1'b0, sz, a, wd, lat, rd);
        n_cmp++;
        if (lat !== n + 1 || rd !== exp) begin
          n_fail++; $display("FAIL rnd_load @%h sz%0d: got lat=%0d d=%h expected lat=%0d d=%h",
                             a, sz, lat, rd, n + 1, exp);
        end
      end else begin
        for (int i = 0; i < n; i++) ref_mem[a + 32'(i)] = wd[8*i +: 8];
        mem_txn(1'b1, sz, a, wd, lat, rd);
        n_cmp++;
        if (lat !== n) begin
          n_fail++; $display("FAIL rnd_store_lat @%h: got %0d expected %0d", a, lat, n);
        end
        for (int i = 0; i <= n; i++) begin
          n_cmp++;
          if (ram_rd(a + 32'(i)) !== ref_rd(a + 32'(i))) begin
            n_fail++; $display("FAIL rnd_store_ram @%h: got %h expected %h", a + 32'(i),
                               ram_rd(a + 32'(i)), ref_rd(a + 32'(i)));
          end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    last_if = 32'h0;
    test_reset();
    test_fetch();
    test_half_store();
    test_arbitration();
    test_flush();
    test_stall();
    test_reset_mid_store();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller that shares the single 8-bit RAM port between the instruction-fetch stage (4-byte reads) and the memory stage (1/2/4-byte loads and stores).
- Sits between stage_if/stage_mem and the external RAM bus, replacing combinational address muxing with a sequenced, arbitrated FSM.
- Assembles and disassembles little-endian words; one-cycle pulse completion handshake per requester.

Parameters:
- ADDR_WIDTH, 32, width of all address ports and the internal address adder.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; low freezes the block
- if_req_i  in  1  fetch request, level, held until if_done_o
- if_addr_i  in  ADDR_WIDTH  fetch address
- if_flush_i  in  1  branch taken; cancels pending/active fetch
- if_done_o  out  1  one-cycle pulse; if_data_o valid
- if_data_o  out  32  fetched instruction
- mem_req_i  in  1  load/store request, level, held until mem_done_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_size_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_addr_i  in  ADDR_WIDTH  load/store base address
- mem_wdata_i  in  32  store data, low bytes used
- mem_done_o  out  1  one-cycle pulse; load data valid / store complete
- mem_rdata_o  out  32  load data, zero-extended (sign extension owned by stage_mem)
- ram_din_i  in  8  RAM read data; byte for address presented in cycle t is valid in cycle t+1
- ram_dout_o  out  8  RAM write data
- ram_addr_o  out  ADDR_WIDTH  RAM address
- ram_wr_o  out  1  1 = write
- busy_o  out  1  state != IDLE

Behaviour:
- Reset: state IDLE, counter 0, all outputs 0 (if_data_o, mem_rdata_o, ram_addr_o, ram_dout_o, ram_wr_o, done pulses, busy_o).
- Reset mid-transaction aborts with no done pulse; partial store bytes already written stay written.
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR, DONE.
- IDLE arbitration, sampled at the clock edge:
  - mem_req_i wins: go to MEM_WR if mem_we_i, else MEM_RD.
  - Otherwise if_req_i && !if_flush_i: go to IF_RD.
  - Address, size and wdata are latched at accept; later input changes are ignored.
- N = bytes: 4 for IF; 1/2/4 for MEM per size.
- Read timing (c0 = first cycle after accept edge):
  - Cycles c0..c(N-1) drive ram_addr_o = base+i, ram_wr_o = 0.
  - Byte i is captured from ram_din_i in c(i+1) into bits [8i+7:8i].
  - The read state lasts N+1 cycles; DONE is entered in c(N+1).
  - Word read: done pulse in the 6th cycle after accept.
  - Unread upper bytes of mem_rdata_o are 0.
- Write timing:
  - Cycles c0..c(N-1) drive ram_addr_o = base+i, ram_dout_o = wdata[8i+7:8i], ram_wr_o = 1.
  - DONE is entered in cN; word store done in the 5th cycle after accept.
- DONE:
  - The relevant done pulse is high for exactly this cycle; no request is accepted in this cycle.
  - Next state is IDLE. Requesters must drop or replace their request by the following edge.
- Data outputs hold their last assembled value until the next capture for that port.
- Address arithmetic is ADDR_WIDTH-bit modulo: 0xFFFFFFFF+1 = 0x00000000.
- if_flush_i:
  - In IF_RD: abort; next state IDLE; no if_done_o; if_data_o unchanged.
  - In IDLE: blocks IF acceptance that cycle.
  - No effect on MEM transactions or on DONE of an IF read already completed.
- rdy low:
  - All registers hold; ram_addr_o holds; ram_wr_o forced 0; done pulses forced 0 and re-emitted when rdy returns.
  - Pending read bytes are captured correctly on resume because the address held during the stall equals the last issued address.
- Between transactions: ram_wr_o = 0, ram_addr_o = 0.
- Simultaneous mem_req_i and if_req_i in IDLE: MEM served first; IF served after its DONE if still requested.

Test Plan:
- Word fetch, RAM[0x100..0x103] = 13,05,A0,00; if_req_i, addr 0x100 -> ram_addr_o 0x100..0x103 in c0..c3; if_done_o in c5 with if_data_o = 0x00A00513; ram_wr_o never 1.
- Half store, mem_we_i = 1, size 01, addr 0x1FFFE, wdata 0xDEADBEEF -> writes EF@0x1FFFE, BE@0x1FFFF in c0,c1 with ram_wr_o = 1; mem_done_o in c2; RAM[0x20000] untouched.
- Same-cycle if_req_i (0x0) and mem_req_i (byte load @0x30000, RAM = 0x80) -> load first, mem_done_o in c2 with mem_rdata_o = 0x00000080; fetch starts after DONE; if_done_o 7 cycles later.
- if_flush_i asserted in c2 of a fetch -> state IDLE next cycle; no if_done_o; a new fetch at 0x200 accepted on the following edge returns RAM[0x200..0x203].
- rdy low for 3 cycles at c2 of a word load -> ram_addr_o held at base+2, ram_wr_o 0; load completes 3 cycles late with the correct byte order.
- rst asserted at c1 of a word store -> next cycle all outputs 0, busy_o 0, no mem_done_o; only base+0 and base+1 written.
